mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control unit for the RV32I-subset core: a Moore state machine that sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback steps. It issues the per-step mux selects, register/PC/IR write enables and memory requests, and waits on a variable-latency memory handshake. It decodes the opcode set of the single-cycle control path and keeps the same 4-bit ALU operation encoding.

## Interface
- MEM_TIMEOUT, 16: cycles a memory wait state may last without mem_ready before bus_err; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0], stable from DECODE until the instruction retires.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write qualifier for mem_req.
- addr_src  out  1  0 PC, 1 ALUOut.
- ir_write, pc_write, reg_write  out  1 each  register enables.
- pc_src  out  1  0 ALU result, 1 ALUOut.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RS1, 11 zero.
- alu_src_b  out  2  00 RS2, 01 Imm, 10 constant 4.
- result_src  out  2  00 ALUOut, 01 MDR, 10 ALU result.
- alu_op  out  4  0000 (add) or {opcode[6:4], opcode[2]}.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- bus_err  out  1  one-cycle pulse on memory timeout.
- illegal_instr  out  1  (MC_TRAP_EN only) sticky trap flag.

## Operation
- Unlisted outputs in each state are 0; alu_op is 0000 unless stated.
- RST: one cycle after reset release, then FETCH.
- FETCH: mem_req, addr_src=0, a=PC, b=4. On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise stay.
- DECODE: a=OldPC, b=Imm. This computes the branch/JAL target into ALUOut. Dispatch on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 and 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_ADDR
  - 0110111 → LUI
  - any other opcode → see Configuration.
- EXEC_R: a=RS1, b=RS2, alu_op=ALUOp, then ALU_WB.
- EXEC_I: a=RS1, b=Imm, alu_op=ALUOp, then ALU_WB.
- ALU_WB: reg_write, result_src=00, then FETCH.
- MEM_ADDR: a=RS1, b=Imm. Go to MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_req, addr_src=1. On mem_ready go to MEM_WB.
- MEM_WB: reg_write, result_src=01, then FETCH.
- MEM_WR: mem_req, mem_we, addr_src=1. On mem_ready go to FETCH.
- BRANCH (bne): a=RS1, b=RS2, alu_op=ALUOp, pc_src=1, pc_write=~zero, then FETCH.
- JAL: a=OldPC, b=4, result_src=10, reg_write, pc_src=1, pc_write, then FETCH.
- JALR_ADDR: a=RS1, b=Imm, then JALR_WB.
- JALR_WB: a=OldPC, b=4, result_src=10, reg_write, pc_src=1, pc_write, then FETCH.
- LUI: a=zero, b=Imm, result_src=10, reg_write, then FETCH.
- instr_done is asserted in ALU_WB, MEM_WB, BRANCH, JAL, JALR_WB and LUI, and in MEM_WR when mem_ready=1.
- Memory timeout applies in the wait states FETCH, MEM_RD and MEM_WR:
  - The counter clears on entry and increments each cycle mem_ready=0.
  - At count MEM_TIMEOUT-1 with mem_ready=0: bus_err=1, mem_req drops next cycle, go to FETCH.
  - PC and register file are unchanged.
  - mem_ready in the same cycle as the timeout wins; no bus_err.

## Timing
- Outputs decode from the state register only, except:
  - ir_write and pc_write in FETCH, which equal mem_ready;
  - mem_ready-gated instr_done in MEM_WR;
  - pc_write in BRANCH, which equals ~zero.
- Cycle counts with zero-wait memory (mem_ready in the request cycle):
  - R/I: 4
  - lw/lbu: 5
  - sw/sb: 4
  - bne: 3
  - jal: 3
  - jalr: 4
  - lui: 3
- Each wait cycle adds one.
- Reset values: state=RST; all outputs 0, including illegal_instr.
- Asserting rst_n low mid-instruction clears all outputs immediately. An in-flight request is abandoned, and mem_ready during reset is ignored.
- mem_ready outside a wait state is ignored.

## Configuration
- MC_TRAP_EN defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP sets illegal_instr=1 and holds all enables at 0 until reset.
- MC_TRAP_EN undefined:
  - An unknown opcode goes straight back to FETCH with instr_done=1, i.e. it executes as a NOP.
  - illegal_instr is not present.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum;
  - opcode localparams;
  - alu_src_a, alu_src_b, result_src and pc_src encodings;
  - ALU_ADD=4'b0000.
- Sub-module mc_wait_timer: timeout counter with clear, enable and expired ports, parameterised by MEM_TIMEOUT. It ties expired to 0 when MEM_TIMEOUT=0.

## Test plan
- Zero-wait addi (0010011): states FETCH→DECODE→EXEC_I→ALU_WB, 4 cycles. reg_write=1 only in cycle 4. alu_op=4'b0010 in EXEC_I.
- lw with mem_ready delayed 3 cycles in both FETCH and MEM_RD: 11 cycles total. ir_write=1 exactly once. result_src=01 with reg_write=1 in the final cycle.
- bne: with zero=1, no pc_write in BRANCH; with zero=0, pc_write=1 and pc_src=1. Both take 3 cycles and pulse instr_done once.
- MEM_TIMEOUT=4, mem_ready never asserted in MEM_WR: bus_err pulses on the 4th MEM_WR cycle, then FETCH. No reg_write.
- rst_n dropped during MEM_RD with mem_req=1: mem_req goes to 0 before the next clock edge. After release: one RST cycle, then FETCH with mem_req=1.
- Opcode 7'b1111111: with MC_TRAP_EN, illegal_instr=1 held and no further mem_req; without it, instr_done in DECODE and then FETCH.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_JALR_ADDR, S_JALR_WB, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic PC_ALU    = 1'b0;
  localparam logic PC_ALUOUT = 1'b1;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  // Same ALU operation encoding as the single-cycle control path.
  function automatic logic [3:0] alu_op_of(input logic [6:0] op);
    return {op[6:4], op[2]};
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Memory request/ready handshake between the control FSM and the memory.
interface mc_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mc_control_fsm_wait_timer.sv
// Memory wait-state timeout counter; expired is tied low when MEM_TIMEOUT is 0.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
      logic [CW-1:0] cnt_r;

      // Count stalled cycles, saturating at the last allowed value
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_r <= '0;
        end else if (clear) begin
          cnt_r <= '0;
        end else if (enable && (cnt_r != LAST)) begin
          cnt_r <= cnt_r + CW'(1);
        end else begin
          cnt_r <= cnt_r;
        end
      end

      assign expired = (cnt_r == LAST);
    end
  endgenerate

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multicycle RV32I-subset datapath.
// Optional feature: define MC_TRAP_EN to trap unknown opcodes (illegal_instr).
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode,
  input  logic              zero,
  mc_control_fsm_if.master  bus,
  output logic              addr_src,
  output logic              ir_write,
  output logic              pc_write,
  output logic              reg_write,
  output logic              pc_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        result_src,
  output logic [3:0]        alu_op,
  output logic              instr_done,
  output logic              bus_err
`ifdef MC_TRAP_EN
  ,
  output logic              illegal_instr
`endif
);

  state_t     state_r, state_nx_s;
  logic       wait_s, timeout_s, expired_s, clear_s, enable_s;
  logic       mem_req_r, mem_we_r, addr_src_r, pc_src_r, reg_write_r, pc_write_r;
  logic       done_r, fetch_r, branch_r, memwr_r;
  logic [1:0] src_a_r, src_b_r, result_r;
  logic [3:0] alu_op_r;

  assign wait_s    = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
  assign enable_s  = wait_s && !bus.mem_ready;
  assign timeout_s = enable_s && expired_s;
  // A timeout back into FETCH does not change state but must still restart the count.
  assign clear_s   = (state_nx_s != state_r) || timeout_s;

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_s),
    .enable  (enable_s),
    .expired (expired_s)
  );

  // Next-state selection
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_RST:      state_nx_s = S_FETCH;
      S_FETCH:    if (bus.mem_ready) state_nx_s = S_DECODE; else state_nx_s = S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:                state_nx_s = S_EXEC_R;
          OP_I:                state_nx_s = S_EXEC_I;
          OP_LOAD, OP_STORE:   state_nx_s = S_MEM_ADDR;
          OP_BRANCH:           state_nx_s = S_BRANCH;
          OP_JAL:              state_nx_s = S_JAL;
          OP_JALR:             state_nx_s = S_JALR_ADDR;
          OP_LUI:              state_nx_s = S_LUI;
          default: begin
`ifdef MC_TRAP_EN
            state_nx_s = S_TRAP;
`else
            state_nx_s = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_nx_s = S_ALU_WB;
      S_MEM_ADDR: if (opcode == OP_LOAD) state_nx_s = S_MEM_RD; else state_nx_s = S_MEM_WR;
      S_MEM_RD: begin
        if (bus.mem_ready)  state_nx_s = S_MEM_WB;
        else if (timeout_s) state_nx_s = S_FETCH;
        else                state_nx_s = S_MEM_RD;
      end
      S_MEM_WR:   if (bus.mem_ready || timeout_s) state_nx_s = S_FETCH; else state_nx_s = S_MEM_WR;
      S_JALR_ADDR: state_nx_s = S_JALR_WB;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR_WB, S_LUI: state_nx_s = S_FETCH;
      S_TRAP:     state_nx_s = S_TRAP;
      default:    state_nx_s = S_RST;
    endcase
  end

  // State register plus registered Moore outputs decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_RST;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      addr_src_r  <= 1'b0;
      pc_src_r    <= PC_ALU;
      reg_write_r <= 1'b0;
      pc_write_r  <= 1'b0;
      done_r      <= 1'b0;
      fetch_r     <= 1'b0;
      branch_r    <= 1'b0;
      memwr_r     <= 1'b0;
      src_a_r     <= SRCA_PC;
      src_b_r     <= SRCB_RS2;
      result_r    <= RES_ALUOUT;
      alu_op_r    <= ALU_ADD;
    end else begin
      state_r     <= state_nx_s;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      addr_src_r  <= 1'b0;
      pc_src_r    <= PC_ALU;
      reg_write_r <= 1'b0;
      pc_write_r  <= 1'b0;
      done_r      <= 1'b0;
      fetch_r     <= 1'b0;
      branch_r    <= 1'b0;
      memwr_r     <= 1'b0;
      src_a_r     <= SRCA_PC;
      src_b_r     <= SRCB_RS2;
      result_r    <= RES_ALUOUT;
      alu_op_r    <= ALU_ADD;
      case (state_nx_s)
        S_FETCH: begin
          mem_req_r <= 1'b1;
          fetch_r   <= 1'b1;
          src_b_r   <= SRCB_FOUR;
        end
        S_DECODE: begin
          src_a_r <= SRCA_OLDPC;
          src_b_r <= SRCB_IMM;
        end
        S_EXEC_R: begin
          src_a_r  <= SRCA_RS1;
          alu_op_r <= alu_op_of(opcode);
        end
        S_EXEC_I: begin
          src_a_r  <= SRCA_RS1;
          src_b_r  <= SRCB_IMM;
          alu_op_r <= alu_op_of(opcode);
        end
        S_MEM_ADDR, S_JALR_ADDR: begin
          src_a_r <= SRCA_RS1;
          src_b_r <= SRCB_IMM;
        end
        S_ALU_WB: begin
          reg_write_r <= 1'b1;
          done_r      <= 1'b1;
        end
        S_MEM_RD: begin
          mem_req_r  <= 1'b1;
          addr_src_r <= 1'b1;
        end
        S_MEM_WB: begin
          reg_write_r <= 1'b1;
          result_r    <= RES_MDR;
          done_r      <= 1'b1;
        end
        S_MEM_WR: begin
          mem_req_r  <= 1'b1;
          mem_we_r   <= 1'b1;
          addr_src_r <= 1'b1;
          memwr_r    <= 1'b1;
        end
        S_BRANCH: begin
          src_a_r  <= SRCA_RS1;
          alu_op_r <= alu_op_of(opcode);
          pc_src_r <= PC_ALUOUT;
          branch_r <= 1'b1;
          done_r   <= 1'b1;
        end
        S_JAL, S_JALR_WB: begin
          src_a_r     <= SRCA_OLDPC;
          src_b_r     <= SRCB_FOUR;
          result_r    <= RES_ALU;
          reg_write_r <= 1'b1;
          pc_src_r    <= PC_ALUOUT;
          pc_write_r  <= 1'b1;
          done_r      <= 1'b1;
        end
        S_LUI: begin
          src_a_r     <= SRCA_ZERO;
          src_b_r     <= SRCB_IMM;
          result_r    <= RES_ALU;
          reg_write_r <= 1'b1;
          done_r      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_TRAP_EN
  logic illegal_r;

  // Sticky trap flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_r || (state_nx_s == S_TRAP);
    end
  end

  assign illegal_instr = illegal_r;
  assign instr_done    = done_r || (memwr_r && bus.mem_ready);
`else
  logic decode_r;
  logic known_s;

  // Tracks DECODE so an unknown opcode can retire there as a NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decode_r <= 1'b0;
    end else begin
      decode_r <= (state_nx_s == S_DECODE);
    end
  end

  // Opcode recognition for the NOP retirement path
  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: known_s = 1'b1;
      default: known_s = 1'b0;
    endcase
  end

  assign instr_done = done_r || (memwr_r && bus.mem_ready) || (decode_r && !known_s);
`endif

  assign bus.mem_req = mem_req_r;
  assign bus.mem_we  = mem_we_r;
  assign addr_src    = addr_src_r;
  assign pc_src      = pc_src_r;
  assign reg_write   = reg_write_r;
  assign alu_src_a   = src_a_r;
  assign alu_src_b   = src_b_r;
  assign result_src  = result_r;
  assign alu_op      = alu_op_r;
  assign ir_write    = fetch_r && bus.mem_ready;
  assign pc_write    = pc_write_r || (fetch_r && bus.mem_ready) || (branch_r && !zero);
  assign bus_err     = timeout_s;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-cycle expected output vectors from a
// state-table reference model, queued as stimulus is driven and compared at negedge.
module tb_mc_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       addr_src, ir_write, pc_write, reg_write, pc_src, instr_done, bus_err;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_op;
`ifdef MC_TRAP_EN
  logic       illegal_instr;
`endif

  mc_control_fsm_if bus ();

  mc_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .bus        (bus),
    .addr_src   (addr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .bus_err    (bus_err)
`ifdef MC_TRAP_EN
    ,
    .illegal_instr (illegal_instr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BNE = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  typedef enum int {
    T_RST, T_FETCH, T_DECODE, T_EXEC_R, T_EXEC_I, T_ALU_WB, T_MEM_ADDR, T_MEM_RD,
    T_MEM_WB, T_MEM_WR, T_BRANCH, T_JAL, T_JALR_ADDR, T_JALR_WB, T_LUI, T_TRAP
  } tst_t;

  typedef struct {
    tst_t       st;
    logic [6:0] op;
    logic       rdy;
    logic       z;
    logic       be;
  } row_t;

  row_t        stim_q[$];
  logic [18:0] exp_q[$];
  int          vectors_applied = 0;
  int          miscompares = 0;

  wire [18:0] act_v = {bus.mem_req, bus.mem_we, addr_src, ir_write, pc_write, reg_write, pc_src,
                       alu_src_a, alu_src_b, result_src, alu_op, instr_done, bus_err};

  function automatic logic known_op(input logic [6:0] op);
    case (op)
      OPC_R, OPC_I, OPC_LW, OPC_SW, OPC_BNE, OPC_JAL, OPC_JR, OPC_LUI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs for one cycle spent in state r.st with the given inputs
  function automatic logic [18:0] model(input row_t r);
    logic mreq, mwe, asrc, irw, pcw, rw, psrc, dn;
    logic [1:0] a, b, rs;
    logic [3:0] aop;
    mreq = 1'b0; mwe = 1'b0; asrc = 1'b0; irw = 1'b0; pcw = 1'b0; rw = 1'b0;
    psrc = 1'b0; dn = 1'b0; a = 2'b00; b = 2'b00; rs = 2'b00; aop = 4'b0000;
    case (r.st)
      T_FETCH:     begin mreq = 1'b1; b = 2'b10; irw = r.rdy; pcw = r.rdy; end
      T_DECODE: begin
        a = 2'b01; b = 2'b01;
`ifndef MC_TRAP_EN
        dn = !known_op(r.op);
`endif
      end
      T_EXEC_R:    begin a = 2'b10; b = 2'b00; aop = {r.op[6:4], r.op[2]}; end
      T_EXEC_I:    begin a = 2'b10; b = 2'b01; aop = {r.op[6:4], r.op[2]}; end
      T_ALU_WB:    begin rw = 1'b1; dn = 1'b1; end
      T_MEM_ADDR:  begin a = 2'b10; b = 2'b01; end
      T_MEM_RD:    begin mreq = 1'b1; asrc = 1'b1; end
      T_MEM_WB:    begin rw = 1'b1; rs = 2'b01; dn = 1'b1; end
      T_MEM_WR:    begin mreq = 1'b1; mwe = 1'b1; asrc = 1'b1; dn = r.rdy; end
      T_BRANCH:    begin a = 2'b10; b = 2'b00; aop = {r.op[6:4], r.op[2]}; psrc = 1'b1; pcw = !r.z; dn = 1'b1; end
      T_JAL, T_JALR_WB: begin a = 2'b01; b = 2'b10; rs = 2'b10; rw = 1'b1; psrc = 1'b1; pcw = 1'b1; dn = 1'b1; end
      T_JALR_ADDR: begin a = 2'b10; b = 2'b01; end
      T_LUI:       begin a = 2'b11; b = 2'b01; rs = 2'b10; rw = 1'b1; dn = 1'b1; end
      default: ;
    endcase
    return {mreq, mwe, asrc, irw, pcw, rw, psrc, a, b, rs, aop, dn, r.be};
  endfunction

  task automatic add(input tst_t st, input logic [6:0] op, input logic rdy, input logic z, input logic be);
    row_t r;
    r.st = st; r.op = op; r.rdy = rdy; r.z = z; r.be = be;
    stim_q.push_back(r);
  endtask

  // Drive one cycle of stimulus, queue its expectation, and stop at the sampling edge
  task automatic drive_row(input row_t r);
    @(posedge clk);
    #1;
    opcode = r.op;
    zero = r.z;
    bus.mem_ready = r.rdy;
    exp_q.push_back(model(r));
    @(negedge clk);
  endtask

  task automatic test_reset();
    row_t r;
    logic [18:0] e;
    r.st = T_RST; r.op = 7'd0; r.rdy = 1'b0; r.z = 1'b0; r.be = 1'b0;
    rst_n = 1'b0; opcode = 7'd0; zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.push_back(model(r));
    @(negedge clk);
    e = exp_q.pop_front();
    vectors_applied++;
    if (act_v !== e) begin miscompares++; $display("FAIL reset_held: got %b want %b", act_v, e); end
`ifdef MC_TRAP_EN
    vectors_applied++;
    if (illegal_instr !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b want 0", illegal_instr); end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(model(r));
    @(negedge clk);
    e = exp_q.pop_front();
    vectors_applied++;
    if (act_v !== e) begin miscompares++; $display("FAIL reset_rst_cycle: got %b want %b", act_v, e); end
  endtask

  task automatic test_addi();
    row_t r;
    logic [18:0] e;
    add(T_FETCH, OPC_I, 1'b1, 1'b0, 1'b0);
    add(T_DECODE, OPC_I, 1'b0, 1'b0, 1'b0);
    add(T_EXEC_I, OPC_I, 1'b0, 1'b0, 1'b0);
    add(T_ALU_WB, OPC_I, 1'b0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive_row(r);
      e = exp_q.pop_front();
      vectors_applied++;
      if (act_v !== e) begin miscompares++; $display("FAIL addi %s: got %b want %b", r.st.name(), act_v, e); end
    end
  endtask

  task automatic test_lw_wait();
    row_t r;
    logic [18:0] e;
    int ir_cnt = 0;
    repeat (3) add(T_FETCH, OPC_LW, 1'b0, 1'b0, 1'b0);
    add(T_FETCH, OPC_LW, 1'b1, 1'b0, 1'b0);
    add(T_DECODE, OPC_LW, 1'b0, 1'b0, 1'b0);
    add(T_MEM_ADDR, OPC_LW, 1'b0, 1'b0, 1'b0);
    repeat (3) add(T_MEM_RD, OPC_LW, 1'b0, 1'b0, 1'b0);
    add(T_MEM_RD, OPC_LW, 1'b1, 1'b0, 1'b0);
    add(T_MEM_WB, OPC_LW, 1'b0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive_row(r);
      if (ir_write === 1'b1) ir_cnt++;
      e = exp_q.pop_front();
      vectors_applied++;
      if (act_v !== e) begin miscompares++; $display("FAIL lw_wait %s: got %b want %b", r.st.name(), act_v, e); end
    end
    vectors_applied++;
    if (ir_cnt !== 1) begin miscompares++; $display("FAIL lw_ir_write_count: got %0d want 1", ir_cnt); end
  endtask

  task automatic test_bne();
    row_t r;
    logic [18:0] e;
    for (int zv = 1; zv >= 0; zv--) begin
      add(T_FETCH, OPC_BNE, 1'b1, zv[0], 1'b0);
      add(T_DECODE, OPC_BNE, 1'b0, zv[0], 1'b0);
      add(T_BRANCH, OPC_BNE, 1'b0, zv[0], 1'b0);
    end
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive_row(r);
      e = exp_q.pop_front();
      vectors_applied++;
      if (act_v !== e) begin miscompares++; $display("FAIL bne_z%0d %s: got %b want %b", r.z, r.st.name(), act_v, e); end
    end
  endtask

  task automatic test_timeout();
    row_t r;
    logic [18:0] e;
    add(T_FETCH, OPC_SW, 1'b1, 1'b0, 1'b0);
    add(T_DECODE, OPC_SW, 1'b0, 1'b0, 1'b0);
    add(T_MEM_ADDR, OPC_SW, 1'b0, 1'b0, 1'b0);
    repeat (3) add(T_MEM_WR, OPC_SW, 1'b0, 1'b0, 1'b0);
    add(T_MEM_WR, OPC_SW, 1'b0, 1'b0, 1'b1);
    repeat (3) add(T_FETCH, OPC_SW, 1'b0, 1'b0, 1'b0);
    add(T_FETCH, OPC_SW, 1'b0, 1'b0, 1'b1);
    add(T_FETCH, OPC_SW, 1'b0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive_row(r);
      e = exp_q.pop_front();
      vectors_applied++;
      if (act_v !== e) begin miscompares++; $display("FAIL timeout %s be%0d: got %b want %b", r.st.name(), r.be, act_v, e); end
    end
  endtask

  task automatic test_back_to_back();
    row_t r;
    logic [18:0] e;
    add(T_FETCH, OPC_R, 1'b1, 1'b0, 1'b0);
    add(T_DECODE, OPC_R, 1'b1, 1'b0, 1'b0);
    add(T_EXEC_R, OPC_R, 1'b1, 1'b0, 1'b0);
    add(T_ALU_WB, OPC_R, 1'b0, 1'b0, 1'b0);
    add(T_FETCH, OPC_SW, 1'b1, 1'b0, 1'b0);
    add(T_DECODE, OPC_SW, 1'b0, 1'b0, 1'b0);
    add(T_MEM_ADDR, OPC_SW, 1'b0, 1'b0, 1'b0);
    add(T_MEM_WR, OPC_SW, 1'b1, 1'b0, 1'b0);
    add(T_FETCH, OPC_JAL, 1'b1, 1'b0, 1'b0);
    add(T_DECODE, OPC_JAL, 1'b0, 1'b0, 1'b0);
    add(T_JAL, OPC_JAL, 1'b0, 1'b0, 1'b0);
    add(T_FETCH, OPC_JR, 1'b1, 1'b0, 1'b0);
    add(T_DECODE, OPC_JR, 1'b0, 1'b0, 1'b0);
    add(T_JALR_ADDR, OPC_JR, 1'b0, 1'b0, 1'b0);
    add(T_JALR_WB, OPC_JR, 1'b0, 1'b0, 1'b0);
    add(T_FETCH, OPC_LUI, 1'b1, 1'b0, 1'b0);
    add(T_DECODE, OPC_LUI, 1'b0, 1'b0, 1'b0);
    add(T_LUI, OPC_LUI, 1'b1, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive_row(r);
      e = exp_q.pop_front();
      vectors_applied++;
      if (act_v !== e) begin miscompares++; $display("FAIL b2b op%b %s: got %b want %b", r.op, r.st.name(), act_v, e); end
    end
  endtask

  task automatic test_reset_mid();
    row_t r, rr;
    logic [18:0] e;
    rr.st = T_RST; rr.op = OPC_LW; rr.rdy = 1'b0; rr.z = 1'b0; rr.be = 1'b0;
    add(T_FETCH, OPC_LW, 1'b1, 1'b0, 1'b0);
    add(T_DECODE, OPC_LW, 1'b0, 1'b0, 1'b0);
    add(T_MEM_ADDR, OPC_LW, 1'b0, 1'b0, 1'b0);
    add(T_MEM_RD, OPC_LW, 1'b0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive_row(r);
      e = exp_q.pop_front();
      vectors_applied++;
      if (act_v !== e) begin miscompares++; $display("FAIL rst_mid_pre %s: got %b want %b", r.st.name(), act_v, e); end
    end
    #2;
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    exp_q.push_back(model(rr));
    #1;
    e = exp_q.pop_front();
    vectors_applied++;
    if (act_v !== e) begin miscompares++; $display("FAIL rst_mid_immediate: got %b want %b", act_v, e); end
    @(posedge clk);
    exp_q.push_back(model(rr));
    @(negedge clk);
    e = exp_q.pop_front();
    vectors_applied++;
    if (act_v !== e) begin miscompares++; $display("FAIL rst_mid_held: got %b want %b", act_v, e); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    exp_q.push_back(model(rr));
    @(negedge clk);
    e = exp_q.pop_front();
    vectors_applied++;
    if (act_v !== e) begin miscompares++; $display("FAIL rst_mid_rst_cycle: got %b want %b", act_v, e); end
    add(T_FETCH, OPC_LW, 1'b0, 1'b0, 1'b0);
    add(T_FETCH, OPC_LW, 1'b1, 1'b0, 1'b0);
    add(T_DECODE, OPC_LW, 1'b0, 1'b0, 1'b0);
    add(T_MEM_ADDR, OPC_LW, 1'b0, 1'b0, 1'b0);
    add(T_MEM_RD, OPC_LW, 1'b1, 1'b0, 1'b0);
    add(T_MEM_WB, OPC_LW, 1'b0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive_row(r);
      e = exp_q.pop_front();
      vectors_applied++;
      if (act_v !== e) begin miscompares++; $display("FAIL rst_mid_post %s: got %b want %b", r.st.name(), act_v, e); end
    end
  endtask

  task automatic test_illegal();
    row_t r;
    logic [18:0] e;
    add(T_FETCH, OPC_BAD, 1'b1, 1'b0, 1'b0);
    add(T_DECODE, OPC_BAD, 1'b0, 1'b0, 1'b0);
`ifdef MC_TRAP_EN
    add(T_TRAP, OPC_BAD, 1'b1, 1'b0, 1'b0);
    add(T_TRAP, OPC_BAD, 1'b0, 1'b0, 1'b0);
    add(T_TRAP, OPC_BAD, 1'b1, 1'b0, 1'b0);
`else
    add(T_FETCH, OPC_BAD, 1'b0, 1'b0, 1'b0);
`endif
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive_row(r);
      e = exp_q.pop_front();
      vectors_applied++;
      if (act_v !== e) begin miscompares++; $display("FAIL illegal %s: got %b want %b", r.st.name(), act_v, e); end
`ifdef MC_TRAP_EN
      vectors_applied++;
      if (illegal_instr !== (r.st == T_TRAP)) begin
        miscompares++;
        $display("FAIL illegal_flag %s: got %b want %b", r.st.name(), illegal_instr, (r.st == T_TRAP));
      end
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_bne();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
